// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and load/store.
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN (aborts with err after TIMEOUT cycles).
module memory_port_arbiter #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic OwnFetch = 1'b0;
    localparam logic OwnData  = 1'b1;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              grant_data;
    logic              timeout_hit;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        grant_data = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    // On a tie, data wins unless it was the last one granted.
                    grant_data = d_req && (!i_req || (last_q == OwnFetch));
                    owner_d    = grant_data;
                    last_d     = grant_data;
                    we_d       = grant_data ? d_we : 1'b0;
                    addr_d     = grant_data ? d_addr : i_addr;
                    wdata_d    = grant_data ? d_wdata : '0;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                if (mem_ack) begin
                    if (owner_q == OwnData) begin
                        d_rdata_d = we_q ? '0 : mem_rdata;
                    end else begin
                        i_rdata_d = mem_rdata;
                    end
                    state_d = StDone;
                end else if (timeout_hit) begin
                    if (owner_q == OwnData) begin
                        d_rdata_d = '0;
                    end else begin
                        i_rdata_d = '0;
                    end
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            owner_q   <= OwnFetch;
            last_q    <= OwnFetch;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [31:0] cnt_q;
    logic        err_q;

    assign timeout_hit = (state_q == StBusy) && !mem_ack && ((cnt_q + 32'd1) >= 32'(TIMEOUT));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if (state_q != StBusy) begin
                cnt_q <= '0;
            end else if (!mem_ack) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign err            = 1'b0;
`endif

    assign mem_req   = (state_q == StBusy);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? addr_q : '0;
    assign mem_wdata = mem_req ? wdata_q : '0;
    assign i_done    = (state_q == StDone) && (owner_q == OwnFetch);
    assign d_done    = (state_q == StDone) && (owner_q == OwnData);
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
